// File: rtl/mem_if_pkg.sv
// Shared definitions for the MI/MO data-memory responder: FSM states,
// default region bases, error-flag bit positions and byte-lane extraction.
package mem_if_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_DONE
  } state_e;

  localparam logic [21:0] BASE_MI = 22'h000000;
  localparam logic [21:0] BASE_MO = 22'h100000;

  localparam int unsigned ERR_BUSY    = 0;
  localparam int unsigned ERR_RDWR    = 1;
  localparam int unsigned ERR_TIMEOUT = 2;

  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    return word[8*lane +: 8];
  endfunction

endpackage

// File: rtl/mi_mo_addr_map.sv
// Byte address to DDR {word, lane, byteenable}; region picked by request type.
module mi_mo_addr_map #(
  parameter int unsigned     ADDR_W     = 24,
  parameter int unsigned     DDR_ADDR_W = 22,
  parameter logic [DDR_ADDR_W-1:0] BASE_MI = 22'h000000,
  parameter logic [DDR_ADDR_W-1:0] BASE_MO = 22'h100000
) (
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic                  is_wr_i,
  output logic [DDR_ADDR_W-1:0] word_o,
  output logic [1:0]            lane_o,
  output logic [3:0]            be_o
);

  logic [DDR_ADDR_W-1:0] base;

  always_comb begin
    base   = is_wr_i ? BASE_MO : BASE_MI;
    // Sum is truncated to DDR_ADDR_W, so out-of-range addresses wrap.
    word_o = base + DDR_ADDR_W'(addr_i[ADDR_W-1:2]);
    lane_o = addr_i[1:0];
    be_o   = is_wr_i ? (4'b0001 << lane_o) : 4'hF;
  end

endmodule

// File: rtl/mi_mo_mem_responder.sv
// Services RD_MI / WR_MO strobes as single Avalon-MM DDR transactions.
// Optional read-response timeout: define MI_MO_RESP_TIMEOUT_EN.
module mi_mo_mem_responder #(
  parameter int unsigned     ADDR_W      = 24,
  parameter int unsigned     DDR_ADDR_W  = 22,
  parameter logic [DDR_ADDR_W-1:0] BASE_MI = 22'h000000,
  parameter logic [DDR_ADDR_W-1:0] BASE_MO = 22'h100000,
  parameter int unsigned     TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_mi,
  input  logic                  wr_mo,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata,
  output logic                  mem_busy,
  output logic                  mem_done,
  output logic [2:0]            err_flags,
  output logic [DDR_ADDR_W-1:0] ddr_address,
  output logic                  ddr_read,
  output logic                  ddr_write,
  output logic [3:0]            ddr_byteenable,
  output logic [31:0]           ddr_writedata,
  input  logic                  ddr_waitrequest,
  input  logic [31:0]           ddr_readdata,
  input  logic                  ddr_readdatavalid
);
  import mem_if_pkg::*;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              is_wr_q;
  logic [7:0]        rdata_q;
  logic [2:0]        err_q;
  logic              busy_q, done_q, rd_q, wr_q;
  logic [1:0]        lane;
  logic [3:0]        be;

`ifdef MI_MO_RESP_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] cnt_q;
`endif

  mi_mo_addr_map #(
    .ADDR_W    (ADDR_W),
    .DDR_ADDR_W(DDR_ADDR_W),
    .BASE_MI   (BASE_MI),
    .BASE_MO   (BASE_MO)
  ) u_map (
    .addr_i (addr_q),
    .is_wr_i(is_wr_q),
    .word_o (ddr_address),
    .lane_o (lane),
    .be_o   (be)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
`ifdef MI_MO_RESP_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      if (state_q != ST_IDLE && (rd_mi || wr_mo))
        err_q[ERR_BUSY] <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (rd_mi) begin
            addr_q  <= addr;
            is_wr_q <= 1'b0;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_RD_REQ;
            if (wr_mo) err_q[ERR_RDWR] <= 1'b1;
          end else if (wr_mo) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            is_wr_q <= 1'b1;
            wr_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_WR_REQ;
          end
        end
        ST_RD_REQ: begin
          if (!ddr_waitrequest) begin
            rd_q <= 1'b0;
            // Response coinciding with acceptance skips RD_WAIT.
            if (ddr_readdatavalid) begin
              rdata_q <= lane_byte(ddr_readdata, lane);
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_RD_WAIT;
`ifdef MI_MO_RESP_TIMEOUT_EN
              cnt_q   <= '0;
`endif
            end
          end
        end
        ST_RD_WAIT: begin
          if (ddr_readdatavalid) begin
            rdata_q <= lane_byte(ddr_readdata, lane);
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
`ifdef MI_MO_RESP_TIMEOUT_EN
          else if (cnt_q == TO_LAST) begin
            rdata_q            <= 8'hFF;
            err_q[ERR_TIMEOUT] <= 1'b1;
            done_q             <= 1'b1;
            state_q            <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        ST_WR_REQ: begin
          if (!ddr_waitrequest) begin
            wr_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rdata          = rdata_q;
  assign mem_busy       = busy_q;
  assign mem_done       = done_q;
  assign err_flags      = err_q;
  assign ddr_read       = rd_q;
  assign ddr_write      = wr_q;
  assign ddr_byteenable = (rd_q || wr_q) ? be : 4'h0;
  assign ddr_writedata  = {4{wdata_q}};

endmodule

// File: tb/tb_mi_mo_mem_responder.sv
// Directed bench for mi_mo_mem_responder: vector table of single transactions
// plus hand sequences for wait states, collisions, reset and response timeout.
module tb_mi_mo_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_mi, wr_mo;
  logic [23:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        mem_busy, mem_done;
  logic [2:0]  err_flags;
  logic [21:0] ddr_address;
  logic        ddr_read, ddr_write;
  logic [3:0]  ddr_byteenable;
  logic [31:0] ddr_writedata;
  logic        ddr_waitrequest;
  logic [31:0] ddr_readdata;
  logic        ddr_readdatavalid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mi_mo_mem_responder #(
    .ADDR_W     (24),
    .DDR_ADDR_W (22),
    .BASE_MI    (22'h000000),
    .BASE_MO    (22'h100000),
    .TIMEOUT_CYC(10)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rd_mi            (rd_mi),
    .wr_mo            (wr_mo),
    .addr             (addr),
    .wdata            (wdata),
    .rdata            (rdata),
    .mem_busy         (mem_busy),
    .mem_done         (mem_done),
    .err_flags        (err_flags),
    .ddr_address      (ddr_address),
    .ddr_read         (ddr_read),
    .ddr_write        (ddr_write),
    .ddr_byteenable   (ddr_byteenable),
    .ddr_writedata    (ddr_writedata),
    .ddr_waitrequest  (ddr_waitrequest),
    .ddr_readdata     (ddr_readdata),
    .ddr_readdatavalid(ddr_readdatavalid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_wr;
    logic [23:0] a;
    logic [7:0]  wd;
    logic [31:0] rdw;
    logic [21:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [7:0]  e_rd;
    int          e_lat;
  } vec_t;

  vec_t vecs[7];

  // Strobe at a negedge, then act as a DDR slave sampling on negedges.
  // Latency counts clock edges from the strobe to the first mem_done sample.
  task automatic run_txn(input logic rd, input logic wr, input logic [23:0] a,
                         input logic [7:0] wd, input logic [31:0] rdw,
                         input int nwait, input int inject_at,
                         output int lat, output logic [21:0] s_addr,
                         output logic [3:0] s_be, output logic [31:0] s_wd,
                         output int hold, output logic saw_rd, output logic saw_wr);
    int   waits;
    logic pend;
    @(negedge clk);
    rd_mi = rd; wr_mo = wr; addr = a; wdata = wd;
    @(negedge clk);
    rd_mi = 1'b0; wr_mo = 1'b0;
    lat = 1; waits = nwait; hold = 0; pend = 1'b0;
    saw_rd = 1'b0; saw_wr = 1'b0; s_addr = '0; s_be = '0; s_wd = '0;
    while (!mem_done && lat < 60) begin
      if (ddr_read || ddr_write) begin
        s_addr = ddr_address; s_be = ddr_byteenable; s_wd = ddr_writedata;
        hold++;
      end
      if (ddr_read)  saw_rd = 1'b1;
      if (ddr_write) saw_wr = 1'b1;
      rd_mi = (lat == inject_at);
      ddr_readdatavalid = pend;
      ddr_readdata      = pend ? rdw : 32'h0;
      pend = 1'b0;
      if (ddr_read || ddr_write) begin
        if (waits > 0) begin
          ddr_waitrequest = 1'b1;
          waits--;
        end else begin
          ddr_waitrequest = 1'b0;
          if (ddr_read) pend = 1'b1;
        end
      end else begin
        ddr_waitrequest = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    rd_mi = 1'b0; ddr_readdatavalid = 1'b0; ddr_waitrequest = 1'b0; ddr_readdata = '0;
  endtask

  int          lat, hold, n, cnt_rd, cnt_done;
  logic [21:0] s_addr;
  logic [3:0]  s_be;
  logic [31:0] s_wd;
  logic        saw_rd, saw_wr;

  initial begin
    vecs[0] = '{1'b0, 24'h000005, 8'h00, 32'hAABBCCDD, 22'h000001, 4'hF, 32'h0,        8'hCC, 3};
    vecs[1] = '{1'b0, 24'h000000, 8'h00, 32'h11223344, 22'h000000, 4'hF, 32'h0,        8'h44, 3};
    vecs[2] = '{1'b0, 24'hFFFFFF, 8'h00, 32'h99887766, 22'h3FFFFF, 4'hF, 32'h0,        8'h99, 3};
    vecs[3] = '{1'b1, 24'h000003, 8'h5A, 32'h0,        22'h100000, 4'h8, 32'h5A5A5A5A, 8'h00, 2};
    vecs[4] = '{1'b1, 24'h000400, 8'hC3, 32'h0,        22'h100100, 4'h1, 32'hC3C3C3C3, 8'h00, 2};
    vecs[5] = '{1'b1, 24'hFFFFFE, 8'h3C, 32'h0,        22'h0FFFFF, 4'h4, 32'h3C3C3C3C, 8'h00, 2};
    vecs[6] = '{1'b0, 24'h00000A, 8'h00, 32'hDEADBEEF, 22'h000002, 4'hF, 32'h0,        8'hAD, 3};

    rst = 1'b1; rd_mi = 1'b0; wr_mo = 1'b0; addr = '0; wdata = '0;
    ddr_waitrequest = 1'b0; ddr_readdata = '0; ddr_readdatavalid = 1'b0;
    #1;
    chk("reset_rdata", {24'h0, rdata}, 32'h0);
    chk("reset_flags", {29'h0, err_flags}, 32'h0);
    chk("reset_cmd", {30'h0, ddr_read, ddr_write}, 32'h0);
    chk("reset_be", {28'h0, ddr_byteenable}, 32'h0);
    chk("reset_busy_done", {30'h0, mem_busy, mem_done}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_txn(!vecs[i].is_wr, vecs[i].is_wr, vecs[i].a, vecs[i].wd, vecs[i].rdw, 0, 0,
              lat, s_addr, s_be, s_wd, hold, saw_rd, saw_wr);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].e_lat);
      chk($sformatf("v%0d_addr", i), {10'h0, s_addr}, {10'h0, vecs[i].e_addr});
      chk($sformatf("v%0d_be", i), {28'h0, s_be}, {28'h0, vecs[i].e_be});
      chk($sformatf("v%0d_busy_at_done", i), {31'h0, mem_busy}, 32'h1);
      if (vecs[i].is_wr) chk($sformatf("v%0d_wdata", i), s_wd, vecs[i].e_wd);
      else               chk($sformatf("v%0d_rdata", i), {24'h0, rdata}, {24'h0, vecs[i].e_rd});
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), {30'h0, mem_done, mem_busy}, 32'h0);
      if (!vecs[i].is_wr) chk($sformatf("v%0d_rdata_hold", i), {24'h0, rdata}, {24'h0, vecs[i].e_rd});
    end
    chk("flags_clean", {29'h0, err_flags}, 32'h0);

    // Write held through two wait states.
    run_txn(1'b0, 1'b1, 24'h000003, 8'h5A, 32'h0, 2, 0, lat, s_addr, s_be, s_wd, hold, saw_rd, saw_wr);
    chk("wr2w_hold", hold, 3);
    chk("wr2w_latency", lat, 4);
    chk("wr2w_addr", {10'h0, s_addr}, 32'h100000);
    chk("wr2w_be", {28'h0, s_be}, 32'h8);
    chk("wr2w_wdata", s_wd, 32'h5A5A5A5A);

    // Simultaneous strobes: read wins.
    run_txn(1'b1, 1'b1, 24'h000000, 8'hEE, 32'h00000055, 0, 0, lat, s_addr, s_be, s_wd, hold, saw_rd, saw_wr);
    chk("both_rd_wr_seen", {30'h0, saw_rd, saw_wr}, 32'h2);
    chk("both_rdata", {24'h0, rdata}, 32'h55);
    chk("both_flags", {29'h0, err_flags}, 32'h2);

    // Second rd_mi while in RD_WAIT is ignored.
    run_txn(1'b1, 1'b0, 24'h000008, 8'h00, 32'h000000A7, 0, 2, lat, s_addr, s_be, s_wd, hold, saw_rd, saw_wr);
    chk("busy_strobe_latency", lat, 3);
    chk("busy_strobe_rdata", {24'h0, rdata}, 32'hA7);
    cnt_rd = 0; cnt_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (ddr_read) cnt_rd++;
      if (mem_done) cnt_done++;
    end
    chk("busy_strobe_extra_txn", cnt_rd + cnt_done, 0);
    chk("busy_strobe_flags", {29'h0, err_flags}, 32'h3);

    // Reset asserted in RD_WAIT.
    @(negedge clk);
    rd_mi = 1'b1; addr = 24'h000004;
    @(negedge clk);
    rd_mi = 1'b0; ddr_waitrequest = 1'b0;
    @(negedge clk);
    chk("rst_mid_pre_busy", {31'h0, mem_busy}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_read", {31'h0, ddr_read}, 32'h0);
    chk("rst_mid_busy", {31'h0, mem_busy}, 32'h0);
    chk("rst_mid_rdata", {24'h0, rdata}, 32'h0);
    chk("rst_mid_flags", {29'h0, err_flags}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ddr_readdatavalid = 1'b1; ddr_readdata = 32'h77777777;
    @(negedge clk);
    ddr_readdatavalid = 1'b0; ddr_readdata = '0;
    cnt_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_done || mem_busy) cnt_done++;
    end
    chk("rst_stray_rvalid", cnt_done, 0);
    chk("rst_stray_rdata", {24'h0, rdata}, 32'h0);

    // Read whose response never arrives on its own.
    @(negedge clk);
    rd_mi = 1'b1; addr = 24'h000000;
    @(negedge clk);
    rd_mi = 1'b0; ddr_waitrequest = 1'b0;
    @(negedge clk);
    n = 0;
    while (!mem_done && n < 40) begin
      @(negedge clk);
      n++;
    end
`ifdef MI_MO_RESP_TIMEOUT_EN
    chk("to_latency", n, 10);
    chk("to_rdata", {24'h0, rdata}, 32'hFF);
    chk("to_flags", {29'h0, err_flags}, 32'h4);
    @(negedge clk);
    ddr_readdatavalid = 1'b1; ddr_readdata = 32'h12345678;
    @(negedge clk);
    ddr_readdatavalid = 1'b0;
    cnt_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_done) cnt_done++;
    end
    chk("to_stray_done", cnt_done, 0);
    chk("to_stray_rdata", {24'h0, rdata}, 32'hFF);
`else
    chk("noto_still_waiting", {30'h0, mem_busy, mem_done}, 32'h2);
    chk("noto_flag2", {31'h0, err_flags[2]}, 32'h0);
    ddr_readdatavalid = 1'b1; ddr_readdata = 32'h12345678;
    @(negedge clk);
    ddr_readdatavalid = 1'b0; ddr_readdata = '0;
    n = 0;
    while (!mem_done && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("noto_late_done", {31'h0, mem_done}, 32'h1);
    chk("noto_late_rdata", {24'h0, rdata}, 32'h78);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
